// File: rtl/div_pkg.sv
// Shared types and field positions for the divider result collector.
// Optional error checking is enabled with DIV_RESULT_ERRCHK_EN.
package div_pkg;

  localparam int BYTE_W      = 8;
  localparam int RES_W       = 64;
  localparam int FP_EXP_MSB  = 62;
  localparam int FP_EXP_LSB  = 55;
  localparam int FP_FRAC_MSB = 54;
  localparam int FP_FRAC_LSB = 32;

  typedef enum logic {
    MODE_DIVR2 = 1'b0,
    MODE_FP32  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // One buffered result: assembled word plus the sign and mode captured with byte 0.
  typedef struct packed {
    mode_e             mode;
    logic              sign;
    logic [RES_W-1:0]  data;
  } res_entry_t;

  localparam int ENTRY_W = $bits(res_entry_t);

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding completed result words.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module result_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/div_result_deser.sv
// Reassembles the 8-byte result frame from the pad divider into a 64-bit word.
// Define DIV_RESULT_ERRCHK_EN to add the frame_err pulse and a saturating restart counter.
module div_result_deser #(
  parameter int BYTE_W      = 8,
  parameter int FRAME_BYTES = 8,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        data_in,
  input  logic                     pull_in,
  input  logic                     sign_in,
  input  logic                     select,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [div_pkg::RES_W-1:0] res_data,
  output logic                     res_sign,
  output logic                     res_mode,
  output logic [7:0]               fp_exp,
  output logic [22:0]              fp_frac,
  output logic                     overflow
`ifdef DIV_RESULT_ERRCHK_EN
  ,
  output logic                     frame_err
`endif
);

  import div_pkg::*;

  localparam int                CNT_W    = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BYTES - 1);
  localparam int                LAST_LSB = (FRAME_BYTES - 1) * BYTE_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] asm_q;
  logic [RES_W-1:0] push_word;
  logic             sign_q;
  mode_e            mode_q;
  logic             start;
  logic             store;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  res_entry_t       push_entry;
  res_entry_t       head;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    store   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pull_in) begin
          start   = 1'b1;
          state_d = COLLECT;
          cnt_d   = CNT_W'(1);
        end
      end
      COLLECT: begin
        if (cnt_q == LAST_CNT) begin
          store   = 1'b1;
          push    = 1'b1;
          cnt_d   = '0;
          state_d = pull_in ? COLLECT : IDLE;
        end else if (cnt_q == '0 || pull_in) begin
          // Mid-frame pull_in drops the partial word and restarts on this byte.
          start = 1'b1;
          cnt_d = CNT_W'(1);
        end else begin
          store = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q  <= '0;
      sign_q <= 1'b0;
      mode_q <= MODE_DIVR2;
    end else begin
      if (start) begin
        asm_q[BYTE_W-1:0] <= data_in;
        sign_q            <= sign_in;
        mode_q            <= mode_e'(select);
      end
      if (store) asm_q[int'(cnt_q)*BYTE_W +: BYTE_W] <= data_in;
    end
  end

  // The last byte goes straight into the pushed word, so the push lands on its own edge.
  always_comb begin
    push_word = asm_q;
    push_word[LAST_LSB +: BYTE_W] = data_in;
  end

  assign push_entry = '{mode: mode_q, sign: sign_q, data: push_word};
  assign pop        = res_ready && !empty;

  result_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_entry),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (push && full && !pop)  overflow <= 1'b1;
  end

  assign res_valid = !empty;
  assign res_data  = empty ? '0   : head.data;
  assign res_sign  = empty ? 1'b0 : head.sign;
  assign res_mode  = empty ? 1'b0 : head.mode;
  assign fp_exp    = (res_mode == MODE_FP32) ? res_data[FP_EXP_MSB:FP_EXP_LSB]   : '0;
  assign fp_frac   = (res_mode == MODE_FP32) ? res_data[FP_FRAC_MSB:FP_FRAC_LSB] : '0;

`ifdef DIV_RESULT_ERRCHK_EN
  logic       restart;
  logic [7:0] err_cnt;

  assign restart = (state_q == COLLECT) && pull_in && (cnt_q != '0) && (cnt_q != LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= restart;
      if (restart && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
